// File: rtl/soc_data_memory_arbiter.sv
// Two-master arbiter for the single-port on-chip data memory.
// Per-cycle grant with owner hold, bounded fairness and a fixed one-cycle read return path.
module soc_data_memory_arbiter #(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 32,
   parameter int HOLD_MAX = 4
) (
   input  logic                clk,
   input  logic                reset,

   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,

   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,

   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   // state | meaning
   // IDLE  | no grant last cycle; contention goes to the master that did not win last
   // OWN0  | master 0 granted last cycle; it keeps the memory while hold_cnt < HOLD_MAX
   // OWN1  | master 1 granted last cycle; it keeps the memory while hold_cnt < HOLD_MAX

   localparam int CNT_W = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t             state;
   logic               last_owner;
   logic [CNT_W-1:0]   hold_cnt;
   logic               rd_pend;
   logic               rd_src;

   logic               req0;
   logic               req1;
   logic               hold_ok;
   logic               raw_gnt0;
   logic               raw_gnt1;
   logic               gnt0;
   logic               gnt1;
   logic               gnt_any;
   logic               gnt_read;
   logic               gnt_write;
   logic               owner_match;

   assign req0    = m0_read | m0_write;
   assign req1    = m1_read | m1_write;
   assign hold_ok = (hold_cnt < CNT_W'(HOLD_MAX));

   always_comb begin
      raw_gnt0 = 1'b0;
      raw_gnt1 = 1'b0;
      if (req0 && !req1) begin
         raw_gnt0 = 1'b1;
      end else if (req1 && !req0) begin
         raw_gnt1 = 1'b1;
      end else if (req0 && req1) begin
         case (state)
            ST_OWN0: begin
               raw_gnt0 = hold_ok;
               raw_gnt1 = ~hold_ok;
            end
            ST_OWN1: begin
               raw_gnt1 = hold_ok;
               raw_gnt0 = ~hold_ok;
            end
            default: begin
               raw_gnt0 = last_owner;
               raw_gnt1 = ~last_owner;
            end
         endcase
      end
   end

   // Nothing may reach the memory while reset is held, even though it is asynchronous.
   assign gnt0    = raw_gnt0 & ~reset;
   assign gnt1    = raw_gnt1 & ~reset;
   assign gnt_any = gnt0 | gnt1;

   assign m0_waitrequest = reset | (req0 & ~gnt0);
   assign m1_waitrequest = reset | (req1 & ~gnt1);

   assign mem_address    = gnt1 ? m1_address    : m0_address;
   assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
   assign gnt_write      = gnt1 ? m1_write      : (gnt0 & m0_write);
   assign gnt_read       = gnt1 ? m1_read       : (gnt0 & m0_read);
   assign mem_chipselect = gnt_any;
   assign mem_write      = gnt_write;
   assign mem_clken      = 1'b1;

   assign owner_match = (state == ST_OWN1) ? gnt1 :
                        (state == ST_OWN0) ? gnt0 : 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_owner <= 1'b1;
         hold_cnt   <= '0;
         rd_pend    <= 1'b0;
         rd_src     <= 1'b0;
      end else begin
         if (!gnt_any) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
         end else begin
            state      <= gnt1 ? ST_OWN1 : ST_OWN0;
            last_owner <= gnt1;
            if (!owner_match)
               hold_cnt <= CNT_W'(1);
            else if (hold_ok)
               hold_cnt <= hold_cnt + CNT_W'(1);
         end
         // A read+write pair is treated as a write: no data comes back.
         rd_pend <= gnt_any & gnt_read & ~gnt_write;
         rd_src  <= gnt1;
      end
   end

   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rd_pend & ~rd_src;
   assign m1_readdatavalid = rd_pend &  rd_src;

endmodule

// File: tb/tb_soc_data_memory_arbiter.sv
// Bench for soc_data_memory_arbiter: behavioural memory slave, reference arbiter and shadow memory,
// directed scenarios followed by randomized two-master traffic.
module tb_soc_data_memory_arbiter;
   localparam int ADDR_W   = 15;
   localparam int DATA_W   = 32;
   localparam int HOLD_MAX = 4;
   localparam int DEPTH    = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              rd  [2];
   logic              wr  [2];
   logic [ADDR_W-1:0] adr [2];
   logic [3:0]        be  [2];
   logic [31:0]       wd  [2];

   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;

   soc_data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .reset(rst),
      .m0_address(adr[0]), .m0_byteenable(be[0]), .m0_read(rd[0]), .m0_write(wr[0]),
      .m0_writedata(wd[0]), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(adr[1]), .m1_byteenable(be[1]), .m1_read(rd[1]), .m1_write(wr[1]),
      .m1_writedata(wd[1]), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   // Memory slave: synchronous single port, registered read data.
   logic [31:0] mem_arr [DEPTH];
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem_arr[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= mem_arr[mem_address];
         end
      end
   end

   // Reference model
   logic [31:0] ref_mem [DEPTH];
   int          owner;       // -1 when nobody was granted last cycle
   int          streak;
   int          last_win;
   logic        rv_exp [2];
   logic [31:0] rd_exp;
   int          cur_g;

   int n_checks = 0;
   int n_fail   = 0;

   logic        obs_w0, obs_w1, obs_rv0, obs_rv1, obs_cs, obs_mw;
   logic [31:0] obs_rd0, obs_rd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int predict();
      logic r0, r1;
      r0 = rd[0] | wr[0];
      r1 = rd[1] | wr[1];
      if (!r0 && !r1) return -1;
      if (r0 && !r1) return 0;
      if (r1 && !r0) return 1;
      if (owner >= 0) return (streak < HOLD_MAX) ? owner : 1 - owner;
      return 1 - last_win;
   endfunction

   task automatic model_reset();
      owner = -1; streak = 0; last_win = 1;
      rv_exp[0] = 1'b0; rv_exp[1] = 1'b0;
   endtask

   task automatic model_step();
      rv_exp[0] = 1'b0; rv_exp[1] = 1'b0;
      if (rst) begin
         model_reset();
      end else if (cur_g < 0) begin
         owner = -1; streak = 0;
      end else begin
         if (wr[cur_g]) begin
            for (int b = 0; b < 4; b++)
               if (be[cur_g][b]) ref_mem[adr[cur_g]][b*8 +: 8] = wd[cur_g][b*8 +: 8];
         end else begin
            rv_exp[cur_g] = 1'b1;
            rd_exp = ref_mem[adr[cur_g]];
         end
         streak = (cur_g == owner) ? ((streak < HOLD_MAX) ? streak + 1 : HOLD_MAX) : 1;
         owner = cur_g;
         last_win = cur_g;
      end
   endtask

   task automatic check_outputs();
      logic [1:0] reqs;
      obs_w0 = m0_waitrequest; obs_w1 = m1_waitrequest;
      obs_rv0 = m0_readdatavalid; obs_rv1 = m1_readdatavalid;
      obs_rd0 = m0_readdata; obs_rd1 = m1_readdata;
      obs_cs = mem_chipselect; obs_mw = mem_write;
      reqs = {rd[1] | wr[1], rd[0] | wr[0]};
      if (rst) begin
         cur_g = -1;
         chk("rst_wait0", obs_w0, 1'b1);
         chk("rst_wait1", obs_w1, 1'b1);
         chk("rst_cs", obs_cs, 1'b0);
         chk("rst_mw", obs_mw, 1'b0);
         chk("rst_rv0", obs_rv0, 1'b0);
         chk("rst_rv1", obs_rv1, 1'b0);
      end else begin
         cur_g = predict();
         chk("wait0", obs_w0, reqs[0] && cur_g != 0);
         chk("wait1", obs_w1, reqs[1] && cur_g != 1);
         chk("cs", obs_cs, cur_g >= 0);
         if (cur_g >= 0) begin
            chk("mem_write", obs_mw, wr[cur_g]);
            chk("mem_addr", mem_address, adr[cur_g]);
            if (wr[cur_g]) begin
               chk("mem_wdata", mem_writedata, wd[cur_g]);
               chk("mem_be", mem_byteenable, be[cur_g]);
            end
         end else begin
            chk("mem_write_idle", obs_mw, 1'b0);
         end
         chk("rv0", obs_rv0, rv_exp[0]);
         chk("rv1", obs_rv1, rv_exp[1]);
         if (rv_exp[0]) chk("rdata0", obs_rd0, rd_exp);
         if (rv_exp[1]) chk("rdata1", obs_rd1, rd_exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_cmd(input int k, input logic r, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [3:0] e, input logic [31:0] d);
      rd[k] = r; wr[k] = w; adr[k] = a; be[k] = e; wd[k] = d;
   endtask

   task automatic idle_all();
      set_cmd(0, 1'b0, 1'b0, '0, 4'h0, '0);
      set_cmd(1, 1'b0, 1'b0, '0, 4'h0, '0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
   endtask

   int          exp_order [9];
   logic [31:0] old20;
   logic [31:0] v;
   int          n_cs;
   int          sel;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom;
         mem_arr[i] = v;
         ref_mem[i] = v;
      end
      mem_arr[16'h0010] = 32'hDEADBEEF;
      ref_mem[16'h0010] = 32'hDEADBEEF;
      mem_readdata = '0;
      old20 = ref_mem[16'h0020];
      idle_all();
      model_reset();
      tick();
      chk("clken", mem_clken, 1'b1);
      rst = 1'b0;
      tick();

      // 1: single read from m0
      set_cmd(0, 1'b1, 1'b0, 15'h0010, 4'hF, '0);
      tick();
      chk("t1_wait", obs_w0, 1'b0);
      idle_all();
      tick();
      chk("t1_rv0", obs_rv0, 1'b1);
      chk("t1_data", obs_rd0, 32'hDEADBEEF);
      chk("t1_rv1", obs_rv1, 1'b0);

      // 2: partial write then read back from m1
      set_cmd(1, 1'b0, 1'b1, 15'h0020, 4'b0011, 32'h12345678);
      tick();
      chk("t2_mw_on", obs_mw, 1'b1);
      set_cmd(1, 1'b1, 1'b0, 15'h0020, 4'hF, '0);
      tick();
      chk("t2_mw_off", obs_mw, 1'b0);
      idle_all();
      tick();
      chk("t2_rv1", obs_rv1, 1'b1);
      chk("t2_data", obs_rd1, {old20[31:16], 16'h5678});

      // 3: both stream reads from reset
      do_reset();
      exp_order = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      set_cmd(0, 1'b1, 1'b0, 15'($urandom), 4'hF, '0);
      set_cmd(1, 1'b1, 1'b0, 15'($urandom), 4'hF, '0);
      for (int c = 0; c < 9; c++) begin
         tick();
         chk($sformatf("t3_w0_%0d", c), obs_w0, exp_order[c] != 0);
         chk($sformatf("t3_w1_%0d", c), obs_w1, exp_order[c] != 1);
         if (cur_g >= 0) adr[cur_g] = 15'($urandom);
      end
      idle_all();
      tick();

      // 4: m0 alone streams 10 reads without stalling
      n_cs = 0;
      for (int c = 0; c < 10; c++) begin
         set_cmd(0, 1'b1, 1'b0, 15'($urandom), 4'hF, '0);
         tick();
         chk($sformatf("t4_nostall_%0d", c), obs_w0, 1'b0);
         if (obs_cs) n_cs++;
      end
      chk("t4_grants", n_cs, 10);
      idle_all();
      tick();

      // 5: reset between read issue and return
      set_cmd(0, 1'b1, 1'b0, 15'h0010, 4'hF, '0);
      tick();
      rst = 1'b1;
      model_reset();
      set_cmd(1, 1'b1, 1'b0, 15'h0011, 4'hF, '0);
      tick();
      chk("t5_no_rv0", obs_rv0, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      chk("t5_m0_first", obs_w0, 1'b0);
      chk("t5_m1_waits", obs_w1, 1'b1);
      idle_all();
      tick();
      tick();

      // 6: read+write together is a write
      set_cmd(0, 1'b1, 1'b1, 15'h0005, 4'hF, 32'hCAFEF00D);
      tick();
      chk("t6_mw", obs_mw, 1'b1);
      set_cmd(0, 1'b1, 1'b0, 15'h0005, 4'hF, '0);
      tick();
      chk("t6_no_rv", obs_rv0, 1'b0);
      idle_all();
      tick();
      chk("t6_data", obs_rd0, 32'hCAFEF00D);

      // Random traffic on a small address window so write/read hazards occur.
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!(rd[k] | wr[k]) || cur_g == k) begin
               sel = int'($urandom_range(0, 3));
               set_cmd(k, sel == 1 || sel == 3, sel >= 2, 15'(16'h0100 + $urandom_range(0, 7)),
                       4'($urandom), $urandom);
            end
         end
         tick();
      end
      idle_all();
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
